axi_fft_ram_bridge: RTL and testbench



---
 rtl/axi_fft_ram_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi_fft_ram_bridge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fft_ram_bridge.sv
// AXI4 slave bridge between the interconnect and the FFT sample RAM.
// Optional WRAP burst support: define AXI_FFT_BRIDGE_WRAP_EN.
module axi_fft_ram_bridge #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int ID_W_WIDTH   = 2,
    parameter int ID_R_WIDTH   = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [ADDR_WIDTH-1:0]     i_AWADDR,
    input  logic [7:0]                i_AWLEN,
    input  logic [2:0]                i_AWSIZE,
    input  logic [1:0]                i_AWBURST,
    input  logic [ID_W_WIDTH-1:0]     i_AWID,
    input  logic                      i_AWVALID,
    output logic                      o_AWREADY,
    input  logic [SAMPLE_WIDTH-1:0]   i_WDATA,
    input  logic [SAMPLE_WIDTH/8-1:0] i_WSTRB,
    input  logic                      i_WVALID,
    input  logic                      i_WLAST,
    output logic                      o_WREADY,
    output logic                      o_BVALID,
    output logic [ID_W_WIDTH-1:0]     o_BID,
    output logic [1:0]                o_BRESP,
    input  logic                      i_BREADY,
    input  logic [ADDR_WIDTH-1:0]     i_ARADDR,
    input  logic [7:0]                i_ARLEN,
    input  logic [2:0]                i_ARSIZE,
    input  logic [1:0]                i_ARBURST,
    input  logic [ID_R_WIDTH-1:0]     i_ARID,
    input  logic                      i_ARVALID,
    output logic                      o_ARREADY,
    output logic [DATA_WIDTH-1:0]     o_RDATA,
    output logic [ID_R_WIDTH-1:0]     o_RID,
    output logic [1:0]                o_RRESP,
    output logic                      o_RVALID,
    output logic                      o_RLAST,
    input  logic                      i_RREADY,
    input  logic [DATA_WIDTH-1:0]     i_DATA_FROM_RAM,
    input  logic                      i_CALC_END,
    input  logic [ADDR_WIDTH-1:0]     i_SAMPLES_NUMBER,
    output logic                      o_DATA_LOADED,
    output logic [SAMPLE_WIDTH-1:0]   o_SAMPLE_ram,
    output logic [ADDR_WIDTH-1:0]     o_SAMPLE_INDEX_ram,
    output logic                      o_WRITE_ram,
    output logic                      o_READ_ram
);

    localparam logic [2:0] W_SIZE = 3'($clog2(SAMPLE_WIDTH / 8));
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
`ifdef AXI_FFT_BRIDGE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

    function automatic logic bad_burst(input logic [1:0] b,
                                       input logic [7:0] l);
        logic wl;
        logic bad;
        wl  = (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
        bad = 1'b1;
        unique case (b)
            2'b00, 2'b01: bad = 1'b0;
            2'b10:        bad = !(WRAP_EN && wl);
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

    // WRAP keeps the upper bits and wraps the low log2(len+1) bits
    function automatic logic [ADDR_WIDTH-1:0] nxt(
        input logic [ADDR_WIDTH-1:0] i,
        input logic [1:0]            b,
        input logic [7:0]            l);
        logic [ADDR_WIDTH-1:0] m;
        logic [ADDR_WIDTH-1:0] r;
        m = ADDR_WIDTH'(l);
        r = i;
        unique case (b)
            2'b01:   r = i + ONE;
            2'b10:   r = (i & ~m) | ((i + ONE) & m);
            default: r = i;
        endcase
        return r;
    endfunction

    state_t                  state, nstate;
    logic                    live, calc_done;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [7:0]              len, cnt;
    logic [8:0]              iss;
    logic [1:0]              burst;
    logic                    berr, werr;
    logic [ID_W_WIDTH-1:0]   bid;
    logic [ID_R_WIDTH-1:0]   rid;
    logic                    infl, infl_err, infl_lst;
    logic [DATA_WIDTH-1:0]   f_data [2];
    logic [1:0]              f_err, f_last;
    logic                    f_wp, f_rp;
    logic [1:0]              f_cnt;

    logic [ADDR_WIDTH-1:0]   wr_start, rd_start, iss_idx;
    logic                    aw_hs, ar_hs, w_hs, b_hs, r_pop;
    logic                    aw_bad, ar_bad, w_last, w_ok, room;
    logic                    issue, iss_err, iss_lst;

    assign wr_start = i_AWADDR >> i_AWSIZE;
    assign rd_start = i_ARADDR >> i_ARSIZE;
    assign aw_bad   = bad_burst(i_AWBURST, i_AWLEN) || (i_AWSIZE != W_SIZE);
    assign ar_bad   = bad_burst(i_ARBURST, i_ARLEN);
    assign aw_hs    = (state == IDLE) && live && i_AWVALID;
    assign ar_hs    = (state == IDLE) && live && calc_done
                      && i_ARVALID && !i_AWVALID;
    assign w_hs     = (state == W_DATA) && i_WVALID;
    assign w_last   = (cnt == len);
    assign w_ok     = !berr && (idx < i_SAMPLES_NUMBER) && (&i_WSTRB);
    assign b_hs     = (state == W_RESP) && i_BREADY;
    assign r_pop    = (f_cnt != 2'd0) && i_RREADY;
    assign room     = (f_cnt + {1'b0, infl}) < (2'd2 + {1'b0, r_pop});

    assign o_AWREADY     = (state == IDLE) && live;
    assign o_ARREADY     = (state == IDLE) && live && calc_done && !i_AWVALID;
    assign o_WREADY      = (state == W_DATA);
    assign o_WRITE_ram   = w_hs && w_ok;
    assign o_SAMPLE_ram  = o_WRITE_ram ? i_WDATA : '0;
    assign o_READ_ram    = issue && !iss_err;
    assign o_SAMPLE_INDEX_ram = o_WRITE_ram ? idx :
                                o_READ_ram  ? iss_idx : '0;
    assign o_BVALID      = (state == W_RESP);
    assign o_BID         = o_BVALID ? bid : '0;
    assign o_BRESP       = (o_BVALID && werr) ? 2'b10 : 2'b00;
    assign o_DATA_LOADED = b_hs;
    assign o_RVALID      = (f_cnt != 2'd0);
    assign o_RDATA       = o_RVALID ? f_data[f_rp] : '0;
    assign o_RRESP       = (o_RVALID && f_err[f_rp]) ? 2'b10 : 2'b00;
    assign o_RLAST       = o_RVALID && f_last[f_rp];
    assign o_RID         = o_RVALID ? rid : '0;

    // Read issue: first beat straight from AR, rest while buffer has room
    always_comb begin
        issue   = 1'b0;
        iss_idx = idx;
        iss_err = berr || (idx >= i_SAMPLES_NUMBER);
        iss_lst = (iss[7:0] == len);
        if (ar_hs) begin
            issue   = 1'b1;
            iss_idx = rd_start;
            iss_err = ar_bad || (rd_start >= i_SAMPLES_NUMBER);
            iss_lst = (i_ARLEN == 8'd0);
        end else if ((state == R_DATA) && !iss[8]
                     && (iss[7:0] <= len) && room) begin
            issue = 1'b1;
        end
    end

    // Next-state selection
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:   if (aw_hs) nstate = W_DATA;
                    else if (ar_hs) nstate = R_DATA;
            W_DATA: if (w_hs && w_last) nstate = W_RESP;
            W_RESP: if (b_hs) nstate = IDLE;
            R_DATA: if (r_pop && f_last[f_rp]) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // State, out-of-reset flag and sticky FFT-done flag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            live      <= 1'b0;
            calc_done <= 1'b0;
        end else begin
            state <= nstate;
            live  <= 1'b1;
            if (aw_hs) calc_done <= 1'b0;
            else if (i_CALC_END) calc_done <= 1'b1;
        end
    end

    // Burst context and beat index generation
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            idx   <= '0;
            len   <= '0;
            cnt   <= '0;
            iss   <= '0;
            burst <= '0;
            berr  <= 1'b0;
            werr  <= 1'b0;
            bid   <= '0;
            rid   <= '0;
        end else if (aw_hs) begin
            idx   <= wr_start;
            len   <= i_AWLEN;
            cnt   <= '0;
            burst <= i_AWBURST;
            berr  <= aw_bad;
            werr  <= aw_bad;
            bid   <= i_AWID;
        end else if (ar_hs) begin
            idx   <= nxt(rd_start, i_ARBURST, i_ARLEN);
            len   <= i_ARLEN;
            iss   <= 9'd1;
            burst <= i_ARBURST;
            berr  <= ar_bad;
            rid   <= i_ARID;
        end else if (w_hs) begin
            idx <= nxt(idx, burst, len);
            cnt <= cnt + 8'd1;
            if (!w_ok || (i_WLAST != w_last)) werr <= 1'b1;
        end else if (issue) begin
            idx <= nxt(idx, burst, len);
            iss <= iss + 9'd1;
        end
    end

    // Tag of the read whose data appears on the RAM bus next cycle
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            infl     <= 1'b0;
            infl_err <= 1'b0;
            infl_lst <= 1'b0;
        end else begin
            infl     <= issue;
            infl_err <= iss_err;
            infl_lst <= iss_lst;
        end
    end

    // Two-entry read data buffer
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            f_data[0] <= '0;
            f_data[1] <= '0;
            f_err     <= '0;
            f_last    <= '0;
            f_wp      <= 1'b0;
            f_rp      <= 1'b0;
            f_cnt     <= '0;
        end else begin
            if (infl) begin
                f_data[f_wp] <= infl_err ? '0 : i_DATA_FROM_RAM;
                f_err[f_wp]  <= infl_err;
                f_last[f_wp] <= infl_lst;
                f_wp         <= ~f_wp;
            end
            if (r_pop) f_rp <= ~f_rp;
            f_cnt <= f_cnt + {1'b0, infl} - {1'b0, r_pop};
        end
    end

endmodule

// File: tb/tb_axi_fft_ram_bridge.sv
// Scoreboard testbench for axi_fft_ram_bridge.
// Expected RAM/AXI events are queued by stimulus and popped by a monitor.
module tb_axi_fft_ram_bridge;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [11:0] i_AWADDR;
    logic [7:0]  i_AWLEN;
    logic [2:0]  i_AWSIZE;
    logic [1:0]  i_AWBURST, i_AWID;
    logic        i_AWVALID;
    logic        o_AWREADY;
    logic [15:0] i_WDATA;
    logic [1:0]  i_WSTRB;
    logic        i_WVALID, i_WLAST, o_WREADY;
    logic        o_BVALID;
    logic [1:0]  o_BID, o_BRESP;
    logic        i_BREADY;
    logic [11:0] i_ARADDR;
    logic [7:0]  i_ARLEN;
    logic [2:0]  i_ARSIZE;
    logic [1:0]  i_ARBURST, i_ARID;
    logic        i_ARVALID, o_ARREADY;
    logic [31:0] o_RDATA;
    logic [1:0]  o_RID, o_RRESP;
    logic        o_RVALID, o_RLAST, i_RREADY;
    logic [31:0] i_DATA_FROM_RAM;
    logic        i_CALC_END;
    logic [11:0] i_SAMPLES_NUMBER;
    logic        o_DATA_LOADED;
    logic [15:0] o_SAMPLE_ram;
    logic [11:0] o_SAMPLE_INDEX_ram;
    logic        o_WRITE_ram, o_READ_ram;

    axi_fft_ram_bridge dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_AWADDR(i_AWADDR), .i_AWLEN(i_AWLEN), .i_AWSIZE(i_AWSIZE),
        .i_AWBURST(i_AWBURST), .i_AWID(i_AWID), .i_AWVALID(i_AWVALID),
        .o_AWREADY(o_AWREADY),
        .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB), .i_WVALID(i_WVALID),
        .i_WLAST(i_WLAST), .o_WREADY(o_WREADY),
        .o_BVALID(o_BVALID), .o_BID(o_BID), .o_BRESP(o_BRESP),
        .i_BREADY(i_BREADY),
        .i_ARADDR(i_ARADDR), .i_ARLEN(i_ARLEN), .i_ARSIZE(i_ARSIZE),
        .i_ARBURST(i_ARBURST), .i_ARID(i_ARID), .i_ARVALID(i_ARVALID),
        .o_ARREADY(o_ARREADY),
        .o_RDATA(o_RDATA), .o_RID(o_RID), .o_RRESP(o_RRESP),
        .o_RVALID(o_RVALID), .o_RLAST(o_RLAST), .i_RREADY(i_RREADY),
        .i_DATA_FROM_RAM(i_DATA_FROM_RAM), .i_CALC_END(i_CALC_END),
        .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER), .o_DATA_LOADED(o_DATA_LOADED),
        .o_SAMPLE_ram(o_SAMPLE_ram), .o_SAMPLE_INDEX_ram(o_SAMPLE_INDEX_ram),
        .o_WRITE_ram(o_WRITE_ram), .o_READ_ram(o_READ_ram)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [11:0] idx; logic [15:0] d; } wexp_t;
    typedef struct { logic [1:0] id; logic [1:0] resp; } bexp_t;
    typedef struct {
        logic [31:0] d; logic [1:0] resp; logic last; logic [1:0] id;
    } rexp_t;

    wexp_t       exp_w[$];
    bexp_t       exp_b[$];
    logic [11:0] exp_rd[$];
    rexp_t       exp_r[$];

    int checks = 0;
    int errors = 0;
    int dl_cnt = 0;
    int n_iss = 0, n_acc = 0, max_out = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // RAM model: data valid one cycle after the read strobe
    logic        ram_pend;
    logic [11:0] ram_idx;
    always @(posedge i_clk)
        i_DATA_FROM_RAM <= ram_pend ? (32'hA500_0000 | 32'(ram_idx))
                                    : 32'hDEAD_BEEF;

    // Monitor: pops expectations whenever the DUT presents an event
    wexp_t       mw;
    bexp_t       mb;
    rexp_t       mr;
    logic        stall_prev = 1'b0;
    logic [37:0] stall_val;
    always @(negedge i_clk) begin
        ram_pend = o_READ_ram;
        ram_idx  = o_SAMPLE_INDEX_ram;
        if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
        if (o_WRITE_ram) begin
            if (exp_w.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                mw = exp_w.pop_front();
                chk("wr_idx", 128'(o_SAMPLE_INDEX_ram), 128'(mw.idx));
                chk("wr_data", 128'(o_SAMPLE_ram), 128'(mw.d));
            end
        end
        if (o_BVALID && i_BREADY) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                mb = exp_b.pop_front();
                chk("bid", 128'(o_BID), 128'(mb.id));
                chk("bresp", 128'(o_BRESP), 128'(mb.resp));
            end
        end
        if (o_DATA_LOADED) dl_cnt++;
        if (o_READ_ram) begin
            n_iss++;
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_idx", 128'(o_SAMPLE_INDEX_ram),
                     128'(exp_rd.pop_front()));
        end
        if (stall_prev)
            chk("r_stable", 128'({o_RVALID, o_RDATA, o_RLAST, o_RRESP, o_RID}),
                128'(stall_val));
        stall_prev = o_RVALID && !i_RREADY;
        stall_val  = {1'b1, o_RDATA, o_RLAST, o_RRESP, o_RID};
        if (o_RVALID && i_RREADY) begin
            n_acc++;
            if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                mr = exp_r.pop_front();
                chk("rdata", 128'(o_RDATA), 128'(mr.d));
                chk("rresp", 128'(o_RRESP), 128'(mr.resp));
                chk("rlast", 128'(o_RLAST), 128'(mr.last));
                chk("rid", 128'(o_RID), 128'(mr.id));
            end
        end
    end

    function automatic logic [76:0] all_outs();
        return {o_AWREADY, o_WREADY, o_BVALID, o_BID, o_BRESP, o_ARREADY,
                o_RDATA, o_RID, o_RRESP, o_RVALID, o_RLAST, o_DATA_LOADED,
                o_SAMPLE_ram, o_SAMPLE_INDEX_ram, o_WRITE_ram, o_READ_ram};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pw(input logic [11:0] i, input logic [15:0] d);
        wexp_t e;
        e.idx = i; e.d = d;
        exp_w.push_back(e);
    endtask

    task automatic pb(input logic [1:0] id, input logic [1:0] r);
        bexp_t e;
        e.id = id; e.resp = r;
        exp_b.push_back(e);
    endtask

    task automatic pr(input logic [31:0] d, input logic [1:0] r,
                      input logic l, input logic [1:0] id);
        rexp_t e;
        e.d = d; e.resp = r; e.last = l; e.id = id;
        exp_r.push_back(e);
    endtask

    task automatic do_aw(input logic [11:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b,
                         input logic [1:0] id);
        int n;
        logic rdy;
        i_AWADDR = a; i_AWLEN = l; i_AWSIZE = s; i_AWBURST = b;
        i_AWID = id; i_AWVALID = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk); rdy = o_AWREADY; step(); n++;
        end while (!rdy && n < 50);
        chk("aw_handshake", 128'(rdy), 1);
        i_AWVALID = 1'b0;
    endtask

    task automatic do_ar(input logic [11:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b,
                         input logic [1:0] id);
        int n;
        logic rdy;
        i_ARADDR = a; i_ARLEN = l; i_ARSIZE = s; i_ARBURST = b;
        i_ARID = id; i_ARVALID = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk); rdy = o_ARREADY; step(); n++;
        end while (!rdy && n < 50);
        chk("ar_handshake", 128'(rdy), 1);
        i_ARVALID = 1'b0;
    endtask

    task automatic do_w(input logic [7:0] l, input logic [15:0] base,
                        input int lastpos, input logic [1:0] strb);
        int n;
        logic rdy;
        for (int k = 0; k <= int'(l); k++) begin
            i_WDATA = base + 16'(k); i_WSTRB = strb;
            i_WLAST = (k == lastpos); i_WVALID = 1'b1;
            n = 0;
            do begin
                @(negedge i_clk); rdy = o_WREADY; step(); n++;
            end while (!rdy && n < 50);
            if (!rdy) chk("w_handshake", 0, 1);
        end
        i_WVALID = 1'b0; i_WLAST = 1'b0;
    endtask

    task automatic do_b();
        int n;
        logic v;
        i_BREADY = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk); v = o_BVALID; step(); n++;
        end while (!v && n < 50);
        chk("b_handshake", 128'(v), 1);
        i_BREADY = 1'b0;
    endtask

    task automatic rd_wait(input logic toggle, output int first_n,
                           output int last_n);
        int n;
        logic done;
        n = 0; first_n = 0; last_n = 0; done = 1'b0;
        while (!done && n < 100) begin
            i_RREADY = toggle ? (n % 3 == 0) : 1'b1;
            @(negedge i_clk); n++;
            if (o_RVALID && first_n == 0) first_n = n;
            if (o_RVALID && i_RREADY && o_RLAST) begin
                done = 1'b1; last_n = n;
            end
            step();
        end
        chk("r_done", 128'(done), 1);
        i_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int f, l;
    initial begin
        i_rstn = 1'b0;
        i_AWADDR = '0; i_AWLEN = '0; i_AWSIZE = '0; i_AWBURST = '0;
        i_AWID = '0; i_AWVALID = 1'b0;
        i_WDATA = '0; i_WSTRB = '0; i_WVALID = 1'b0; i_WLAST = 1'b0;
        i_BREADY = 1'b0;
        i_ARADDR = '0; i_ARLEN = '0; i_ARSIZE = '0; i_ARBURST = '0;
        i_ARID = '0; i_ARVALID = 1'b0; i_RREADY = 1'b0;
        i_CALC_END = 1'b0; i_SAMPLES_NUMBER = 12'd8;
        repeat (2) step();
        @(negedge i_clk);
        chk("reset_outputs", 128'(all_outs()), 0);
        step();
        i_rstn = 1'b1;
        repeat (2) step();
        @(negedge i_clk);
        chk("awready_idle", 128'(o_AWREADY), 1);
        step();

        // INCR 8-beat write, indices 0..7
        for (int k = 0; k < 8; k++) pw(12'(k), 16'h1000 + 16'(k));
        pb(2'd1, 2'b00);
        do_aw(12'h000, 8'd7, 3'd1, 2'b01, 2'd1);
        do_w(8'd7, 16'h1000, 7, 2'b11);
        do_b();
        chk("data_loaded_once", 128'(dl_cnt), 1);

        // AR refused until CALC_END, then INCR read 8..11
        i_SAMPLES_NUMBER = 12'd16;
        i_ARVALID = 1'b1;
        @(negedge i_clk);
        chk("arready_before_calc", 128'(o_ARREADY), 0);
        step();
        i_CALC_END = 1'b1;
        step();
        i_CALC_END = 1'b0;
        for (int k = 8; k < 12; k++) exp_rd.push_back(12'(k));
        pr(32'hA500_0008, 2'b00, 1'b0, 2'd2);
        pr(32'hA500_0009, 2'b00, 1'b0, 2'd2);
        pr(32'hA500_000A, 2'b00, 1'b0, 2'd2);
        pr(32'hA500_000B, 2'b00, 1'b1, 2'd2);
        do_ar(12'h010, 8'd3, 3'd1, 2'b01, 2'd2);
        rd_wait(1'b0, f, l);
        chk("r_first_latency", 128'(f), 2);
        chk("r_last_cycle", 128'(l), 5);

        // RREADY toggling 1,0,0 over a 6-beat read
        for (int k = 0; k < 6; k++) exp_rd.push_back(12'(k));
        pr(32'hA500_0000, 2'b00, 1'b0, 2'd3);
        pr(32'hA500_0001, 2'b00, 1'b0, 2'd3);
        pr(32'hA500_0002, 2'b00, 1'b0, 2'd3);
        pr(32'hA500_0003, 2'b00, 1'b0, 2'd3);
        pr(32'hA500_0004, 2'b00, 1'b0, 2'd3);
        pr(32'hA500_0005, 2'b00, 1'b1, 2'd3);
        do_ar(12'h000, 8'd5, 3'd1, 2'b01, 2'd3);
        rd_wait(1'b1, f, l);
        chk("max_outstanding_le2", 128'(max_out <= 2), 1);

        // Read crossing the valid sample count
        i_SAMPLES_NUMBER = 12'd8;
        exp_rd.push_back(12'd7);
        pr(32'hA500_0007, 2'b00, 1'b0, 2'd1);
        pr(32'h0000_0000, 2'b10, 1'b1, 2'd1);
        do_ar(12'h00E, 8'd1, 3'd1, 2'b01, 2'd1);
        rd_wait(1'b0, f, l);

        // AW beats AR and CALC_END in the same cycle
        i_AWADDR = 12'h002; i_AWLEN = 8'd0; i_AWSIZE = 3'd1;
        i_AWBURST = 2'b01; i_AWID = 2'd2; i_AWVALID = 1'b1;
        i_ARADDR = 12'h000; i_ARLEN = 8'd0; i_ARSIZE = 3'd1;
        i_ARBURST = 2'b01; i_ARID = 2'd0; i_ARVALID = 1'b1;
        i_CALC_END = 1'b1;
        @(negedge i_clk);
        chk("prio_awready", 128'(o_AWREADY), 1);
        chk("prio_arready", 128'(o_ARREADY), 0);
        step();
        i_AWVALID = 1'b0; i_CALC_END = 1'b0;
        pw(12'd1, 16'h4000);
        pb(2'd2, 2'b00);
        do_w(8'd0, 16'h4000, 0, 2'b11);
        do_b();
        @(negedge i_clk);
        chk("calc_done_cleared", 128'(o_ARREADY), 0);
        step();
        i_ARVALID = 1'b0;

        // Early WLAST
        for (int k = 0; k < 4; k++) pw(12'(k), 16'h2000 + 16'(k));
        pb(2'd0, 2'b10);
        do_aw(12'h000, 8'd3, 3'd1, 2'b01, 2'd0);
        do_w(8'd3, 16'h2000, 1, 2'b11);
        do_b();

        // Wrong AWSIZE
        pb(2'd3, 2'b10);
        do_aw(12'h000, 8'd1, 3'd2, 2'b01, 2'd3);
        do_w(8'd1, 16'h5000, 1, 2'b11);
        do_b();

        // WRAP burst 6,7,4,5
`ifdef AXI_FFT_BRIDGE_WRAP_EN
        pw(12'd6, 16'h3000); pw(12'd7, 16'h3001);
        pw(12'd4, 16'h3002); pw(12'd5, 16'h3003);
        pb(2'd1, 2'b00);
`else
        pb(2'd1, 2'b10);
`endif
        do_aw(12'h00C, 8'd3, 3'd1, 2'b10, 2'd1);
        do_w(8'd3, 16'h3000, 3, 2'b11);
        do_b();

        // Partial strobe
        pb(2'd2, 2'b10);
        do_aw(12'h004, 8'd0, 3'd1, 2'b01, 2'd2);
        do_w(8'd0, 16'h6000, 0, 2'b01);
        do_b();

        // Write crossing the valid sample count
        pw(12'd7, 16'h7000);
        pb(2'd0, 2'b10);
        do_aw(12'h00E, 8'd1, 3'd1, 2'b01, 2'd0);
        do_w(8'd1, 16'h7000, 1, 2'b11);
        do_b();

        // FIXED burst on index 3
        pw(12'd3, 16'h8000); pw(12'd3, 16'h8001); pw(12'd3, 16'h8002);
        pb(2'd1, 2'b00);
        do_aw(12'h006, 8'd2, 3'd1, 2'b00, 2'd1);
        do_w(8'd2, 16'h8000, 2, 2'b11);
        do_b();
        chk("data_loaded_total", 128'(dl_cnt), 8);

        // Reset at beat 3 of an 8-beat write
        pw(12'd0, 16'h9000); pw(12'd1, 16'h9001); pw(12'd2, 16'h9002);
        do_aw(12'h000, 8'd7, 3'd1, 2'b01, 2'd1);
        do_w(8'd2, 16'h9000, 99, 2'b11);
        i_WDATA = 16'h9003; i_WSTRB = 2'b11; i_WVALID = 1'b1;
        i_rstn = 1'b0;
        @(negedge i_clk);
        chk("midburst_reset_outputs", 128'(all_outs()), 0);
        step();
        i_rstn = 1'b1; i_WVALID = 1'b0;
        step();
        @(negedge i_clk);
        chk("awready_after_reset", 128'(o_AWREADY), 1);
        chk("arready_after_reset", 128'(o_ARREADY), 0);
        chk("no_write_after_reset", 128'(o_WRITE_ram), 0);
        repeat (3) step();

        chk("exp_w_drained", 128'(exp_w.size()), 0);
        chk("exp_b_drained", 128'(exp_b.size()), 0);
        chk("exp_rd_drained", 128'(exp_rd.size()), 0);
        chk("exp_r_drained", 128'(exp_r.size()), 0);
        chk("data_loaded_final", 128'(dl_cnt), 8);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
